// File: rtl/axi_dma_copy_master_if.sv
// AXI4 master-side channel bundle for the block-copy DMA initiator.
// The master modport is the DMA side; the slave modport is the interconnect/memory side.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

interface axi_dma_copy_master_if;
    logic [`AXI_ID_BITS-1:0]   ARID_M;
    logic [`AXI_ADDR_BITS-1:0] ARADDR_M;
    logic [`AXI_LEN_BITS-1:0]  ARLEN_M;
    logic [2:0]                ARSIZE_M;
    logic [1:0]                ARBURST_M;
    logic                      ARVALID_M;
    logic                      ARREADY_M;

    logic [`AXI_ID_BITS-1:0]   RID_M;
    logic [`AXI_DATA_BITS-1:0] RDATA_M;
    logic [1:0]                RRESP_M;
    logic                      RLAST_M;
    logic                      RVALID_M;
    logic                      RREADY_M;

    logic [`AXI_ID_BITS-1:0]   AWID_M;
    logic [`AXI_ADDR_BITS-1:0] AWADDR_M;
    logic [`AXI_LEN_BITS-1:0]  AWLEN_M;
    logic [2:0]                AWSIZE_M;
    logic [1:0]                AWBURST_M;
    logic                      AWVALID_M;
    logic                      AWREADY_M;

    logic [`AXI_DATA_BITS-1:0] WDATA_M;
    logic [`AXI_STRB_BITS-1:0] WSTRB_M;
    logic                      WLAST_M;
    logic                      WVALID_M;
    logic                      WREADY_M;

    logic [`AXI_ID_BITS-1:0]   BID_M;
    logic [1:0]                BRESP_M;
    logic                      BVALID_M;
    logic                      BREADY_M;

    modport master (
        output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
        input  ARREADY_M,
        input  RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
        output RREADY_M,
        output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
        input  AWREADY_M,
        output WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
        input  WREADY_M,
        input  BID_M, BRESP_M, BVALID_M,
        output BREADY_M
    );

    modport slave (
        input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
        output ARREADY_M,
        output RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
        input  RREADY_M,
        input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
        output AWREADY_M,
        input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
        output WREADY_M,
        output BID_M, BRESP_M, BVALID_M,
        input  BREADY_M
    );
endinterface

// File: rtl/axi_dma_copy_master.sv
// AXI4 block-copy initiator: reads up to MAX_BURST words per INCR burst into a
// local buffer, then writes them back out as one INCR burst to the destination.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module axi_dma_copy_master #(
    parameter logic [`AXI_ID_BITS-1:0] ID = '0,
    parameter int MAX_BURST = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      start,
    input  logic [`AXI_ADDR_BITS-1:0] src_addr,
    input  logic [`AXI_ADDR_BITS-1:0] dst_addr,
    input  logic [15:0]               len_words,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    axi_dma_copy_master_if.master     m
);
    localparam int AW = `AXI_ADDR_BITS;
    localparam int LW = `AXI_LEN_BITS;
    localparam int DW = `AXI_DATA_BITS;
    localparam int BW = LW + 1;
    localparam int IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE} state_t;
    state_t state_q, state_d;

    logic [AW-1:0] src_q, dst_q;
    logic [15:0]   rem_q;
    logic [IW-1:0] beat_q;
    logic          gap_q, rd_err_q, error_q;
    logic [DW-1:0] buf_q [2**IW];

    logic [BW-1:0] beats, beats_m1;
    logic          last_beat, ar_hs, r_hs, aw_hs, w_hs, b_hs, r_bad;
    logic          unused_bits;

    assign beats     = (rem_q >= 16'(MAX_BURST)) ? BW'(MAX_BURST) : rem_q[BW-1:0];
    assign beats_m1  = beats - BW'(1);
    assign last_beat = ({{(BW-IW){1'b0}}, beat_q} == beats_m1);

    assign ar_hs = m.ARVALID_M & m.ARREADY_M;
    assign r_hs  = m.RVALID_M  & m.RREADY_M;
    assign aw_hs = m.AWVALID_M & m.AWREADY_M;
    assign w_hs  = m.WVALID_M  & m.WREADY_M;
    assign b_hs  = m.BVALID_M  & m.BREADY_M;
    assign r_bad = (m.RRESP_M != 2'b00) || (m.RLAST_M != last_beat);

    assign unused_bits = ^{m.RID_M, m.BID_M, src_addr[1:0], dst_addr[1:0]};

    // Payloads are zeroed whenever their VALID is low so reset leaves the bus quiet.
    assign m.ARID_M    = ID;
    assign m.ARSIZE_M  = 3'b010;
    assign m.ARBURST_M = 2'b01;
    assign m.ARVALID_M = (state_q == RD_ADDR);
    assign m.ARADDR_M  = m.ARVALID_M ? src_q : '0;
    assign m.ARLEN_M   = m.ARVALID_M ? beats_m1[LW-1:0] : '0;
    assign m.RREADY_M  = (state_q == RD_DATA);

    assign m.AWID_M    = ID;
    assign m.AWSIZE_M  = 3'b010;
    assign m.AWBURST_M = 2'b01;
    assign m.AWVALID_M = (state_q == WR_ADDR) && !gap_q;
    assign m.AWADDR_M  = m.AWVALID_M ? dst_q : '0;
    assign m.AWLEN_M   = m.AWVALID_M ? beats_m1[LW-1:0] : '0;

    assign m.WVALID_M  = (state_q == WR_DATA) && !gap_q;
    assign m.WDATA_M   = m.WVALID_M ? buf_q[beat_q] : '0;
    assign m.WSTRB_M   = m.WVALID_M ? '1 : '0;
    assign m.WLAST_M   = m.WVALID_M && last_beat;
    assign m.BREADY_M  = (state_q == WR_RESP);

    assign busy  = (state_q != IDLE) && (state_q != DONE);
    assign done  = (state_q == DONE);
    assign error = error_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (len_words == '0) ? DONE : RD_ADDR;
            RD_ADDR: if (ar_hs) state_d = RD_DATA;
            RD_DATA: if (r_hs && last_beat) state_d = (rd_err_q || r_bad) ? DONE : WR_ADDR;
            WR_ADDR: if (aw_hs) state_d = WR_DATA;
            WR_DATA: if (w_hs && last_beat) state_d = WR_RESP;
            WR_RESP: if (b_hs) state_d = ((m.BRESP_M != 2'b00) || (rem_q == 16'(beats))) ? DONE : RD_ADDR;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            beat_q   <= '0;
            gap_q    <= 1'b0;
            rd_err_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            // One dead cycle on entry to WR_ADDR and WR_DATA keeps the bubble the slaves expect.
            gap_q   <= (state_d != state_q) && ((state_d == WR_ADDR) || (state_d == WR_DATA));
            if (state_q == IDLE && start) begin
                src_q   <= {src_addr[AW-1:2], 2'b00};
                dst_q   <= {dst_addr[AW-1:2], 2'b00};
                rem_q   <= len_words;
                error_q <= 1'b0;
            end
            if (ar_hs) begin
                beat_q   <= '0;
                rd_err_q <= 1'b0;
            end
            if (r_hs) begin
                beat_q <= beat_q + IW'(1);
                if (r_bad) begin
                    rd_err_q <= 1'b1;
                    error_q  <= 1'b1;
                end
            end
            if (aw_hs) beat_q <= '0;
            if (w_hs)  beat_q <= beat_q + IW'(1);
            if (b_hs) begin
                if (m.BRESP_M != 2'b00) begin
                    error_q <= 1'b1;
                end else begin
                    src_q <= src_q + AW'({beats, 2'b00});
                    dst_q <= dst_q + AW'({beats, 2'b00});
                    rem_q <= rem_q - 16'(beats);
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (r_hs) buf_q[beat_q] <= m.RDATA_M;
    end
endmodule
